ramfifo_single_slow: RTL and testbench

RAMFIFO_SINGLE_SLOW -- requirements
Module: ramfifo_single_slow

---
 rtl/ramfifo_single_slow.sv | 98 +++++++++
 tb/tb_ramfifo_single_slow.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ramfifo_single_slow.sv
// Single-clock RAM-backed FIFO with a registered head word. A popped word
// leaves a one-cycle has_data bubble before the next word is fetched.
module ramfifo_single_slow #(
  parameter int WIDTH   = 16,
  parameter int LOG_DEP = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write,
  input  logic             read,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             has_data
);

  localparam int DEPTH = 1 << LOG_DEP;

  localparam logic [LOG_DEP-1:0] PTR_ONE    = {{(LOG_DEP-1){1'b0}}, 1'b1};
  localparam logic [LOG_DEP:0]   CNT_ONE    = {{LOG_DEP{1'b0}}, 1'b1};
  localparam logic [LOG_DEP:0]   CNT_ZERO   = '0;
  localparam logic [LOG_DEP:0]   FULL_COUNT = {1'b1, {LOG_DEP{1'b0}}};

  logic [WIDTH-1:0]   mem [DEPTH];

  logic [LOG_DEP-1:0] wr_ptr_q,   wr_ptr_d;
  logic [LOG_DEP-1:0] rd_ptr_q,   rd_ptr_d;
  logic [LOG_DEP:0]   count_q,    count_d;
  logic               has_data_q, has_data_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               full_q,     full_d;
  logic               empty_q,    empty_d;

  logic wr_acc;
  logic rd_acc;

  assign wr_acc = write && !full_q;
  assign rd_acc = read && has_data_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    has_data_d = has_data_q;
    data_out_d = data_out_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (wr_acc && !rd_acc)      count_d = count_q + CNT_ONE;
    else if (!wr_acc && rd_acc) count_d = count_q - CNT_ONE;

    // Fetch uses the registered count, so a word written this edge is not
    // visible until the next edge (no write-to-output bypass).
    if (rd_acc) begin
      has_data_d = 1'b0;
    end else if (!has_data_q && count_q != CNT_ZERO) begin
      has_data_d = 1'b1;
      data_out_d = mem[rd_ptr_q];
    end

    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == CNT_ZERO);
  end

  // NOTE: the storage array has no reset; stale contents are unreachable
  // because the pointers and count are cleared.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      has_data_q <= 1'b0;
      data_out_q <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      has_data_q <= has_data_d;
      data_out_q <= data_out_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  assign data_out = data_out_q;
  assign has_data = has_data_q;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: tb/tb_ramfifo_single_slow.sv
// Bench for ramfifo_single_slow: directed scenarios followed by random traffic,
// all compared against a queue-based reference of the FIFO's observable rules.
module tb_ramfifo_single_slow;

  localparam int WIDTH   = 16;
  localparam int LOG_DEP = 3;
  localparam int DEPTH   = 1 << LOG_DEP;

  logic             clock = 1'b0;
  logic             reset;
  logic             write;
  logic             read;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             has_data;

  int vectors     = 0;
  int miscompares = 0;

  // Reference: every unpopped word in order, whether the head is presented,
  // and the last value shown on data_out.
  logic [WIDTH-1:0] mq[$];
  bit               m_hd;
  logic [WIDTH-1:0] m_dout;

  ramfifo_single_slow #(.WIDTH(WIDTH), .LOG_DEP(LOG_DEP)) dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .write    (write),
    .read     (read),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .has_data (has_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit w, input bit r, input logic [WIDTH-1:0] d, input bit rst);
    bit wacc, racc, fetch;
    write   = w;
    read    = r;
    data_in = d;
    reset   = rst;
    @(posedge clock);
    if (rst) begin
      mq.delete();
      m_hd   = 1'b0;
      m_dout = '0;
    end else begin
      wacc  = w && (mq.size() < DEPTH);
      racc  = r && m_hd;
      fetch = !m_hd && (mq.size() > 0);
      if (racc) begin
        void'(mq.pop_front());
        m_hd = 1'b0;
      end else if (fetch) begin
        m_hd   = 1'b1;
        m_dout = mq[0];
      end
      if (wacc) mq.push_back(d);
    end
    #1;
    check("full",     full,     (mq.size() == DEPTH));
    check("empty",    empty,    (mq.size() == 0));
    check("has_data", has_data, m_hd);
    check("data_out", data_out, m_dout);
  endtask

  // Holds read high until a word is presented (bounded), checks it, pops it.
  task automatic pop_expect(input string tag, input logic [WIDTH-1:0] exp);
    int waited = 0;
    while (!has_data && waited < 4) begin
      step(1'b0, 1'b1, '0, 1'b0);
      waited++;
    end
    check({tag, "_present"}, has_data, 1'b1);
    check(tag, data_out, exp);
    step(1'b0, 1'b1, '0, 1'b0);
    check({tag, "_bubble"}, has_data, 1'b0);
  endtask

  initial begin
    write = 1'b0; read = 1'b0; data_in = '0; reset = 1'b1;
    mq.delete(); m_hd = 1'b0; m_dout = '0;

    // Reset, no traffic
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    check("rst_empty",    empty,    1'b1);
    check("rst_full",     full,     1'b0);
    check("rst_has_data", has_data, 1'b0);
    check("rst_data_out", data_out, 16'h0000);

    // Fill with 1..9; the 9th is dropped
    step(1'b1, 1'b0, 16'd1, 1'b0);
    check("lat_edge1_hd", has_data, 1'b0);
    step(1'b1, 1'b0, 16'd2, 1'b0);
    check("lat_edge2_hd", has_data, 1'b1);
    check("lat_edge2_do", data_out, 16'd1);
    for (int i = 3; i <= 9; i++) begin
      step(1'b1, 1'b0, WIDTH'(i), 1'b0);
      if (i == 8) check("full_after_8", full, 1'b1);
    end
    check("full_after_9", full, 1'b1);

    // Pop four words with read held high
    pop_expect("pop1", 16'd1);
    check("full_cleared", full, 1'b0);
    pop_expect("pop2", 16'd2);
    pop_expect("pop3", 16'd3);
    pop_expect("pop4", 16'd4);

    // Simultaneous read+write with occupancy 4
    step(1'b0, 1'b0, '0, 1'b0);
    check("rw_hd", has_data, 1'b1);
    check("rw_head", data_out, 16'd5);
    step(1'b1, 1'b1, 16'hCAFE, 1'b0);
    check("rw_count_kept", mq.size() == 4 && !empty && !full, 1'b1);
    pop_expect("pop6", 16'd6);
    pop_expect("pop7", 16'd7);
    pop_expect("pop8", 16'd8);
    pop_expect("popcafe", 16'hCAFE);
    check("drained_empty", empty, 1'b1);

    // Wrap-around ordering
    step(1'b1, 1'b0, 16'hEDAF, 1'b0);
    step(1'b1, 1'b0, 16'h2345, 1'b0);
    step(1'b1, 1'b0, 16'h3456, 1'b0);
    check("wrap_head", data_out, 16'hEDAF);
    step(1'b1, 1'b1, 16'h1234, 1'b0);
    pop_expect("wrap2", 16'h2345);
    pop_expect("wrap3", 16'h3456);
    pop_expect("wrap4", 16'h1234);
    check("wrap_empty", empty, 1'b1);

    // Mid-operation reset
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'(16'h0100 + i), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    check("midrst_empty", empty, 1'b1);
    check("midrst_hd", has_data, 1'b0);
    step(1'b1, 1'b0, 16'h00AA, 1'b0);
    pop_expect("post_rst", 16'h00AA);

    // Random traffic: write-heavy phase then read-heavy phase
    for (int i = 0; i < 600; i++) begin
      bit w, r, rst;
      w   = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r   = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 149) == 0);
      step(w, r, WIDTH'($urandom), rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
